mem_port_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Sequences each access over a fixed, parameterised number of memory cycles.
- Returns read data and a one-cycle ready pulse to the requester.
- Drives stall signals into pc and the PipeReg stall inputs while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between the instruction-fetch port and
// the data port. Each granted access occupies the memory for LAT cycles,
// then spends one DONE cycle pulsing the requester's ready before the
// arbiter returns to IDLE. Simultaneous requests alternate round-robin.
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int CW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          LAT_ONE  = (LAT == 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_d;    // 1: most recent grant went to the data port
  logic          op_write;  // latched operation of the current data access
  logic          d_pend;
  logic          grant_d;

  assign d_pend    = d_read | d_write;
  // Data wins when alone, or when both pend and fetch was granted last.
  assign grant_d   = d_pend & (~if_req | ~last_d);
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_pend & ~d_ready;

  // Arbitration FSM; memory-side signals double as the latched request, so
  // they are loaded on grant and cleared on completion. mem_write is set one
  // cycle early (counter==1, or at grant when LAT==1) so it is high only in
  // the final busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      op_write  <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_pend || if_req) begin
            cnt    <= CNT_INIT;
            last_d <= grant_d;
            if (grant_d) begin
              state     <= BUSY_D;
              op_write  <= d_write;
              mem_adr   <= d_adr;
              mem_wdata <= d_wdata;
              mem_read  <= ~d_write;
              mem_write <= d_write & LAT_ONE;
            end else begin
              state     <= BUSY_I;
              op_write  <= 1'b0;
              mem_adr   <= if_adr;
              mem_wdata <= '0;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt == '0) begin
            if (state == BUSY_I) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end else begin
              d_rdata <= op_write ? '0 : mem_rdata;
              d_ready <= 1'b1;
            end
            state     <= DONE;
            op_write  <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end else begin
            cnt       <= cnt - CNT_ONE;
            mem_write <= op_write & (cnt == CNT_ONE);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
